// File: rtl/fb_dual_bank.sv
// Double-buffered framebuffer: the GPU writes the back bank, a row-major scan engine streams the front bank.
// Banks swap on frame_done once the scan and clear engines are both idle.
module fb_dual_bank #(
   parameter int              H_RES     = 640,
   parameter int              V_RES     = 480,
   parameter int              PIX_W     = 6,
   parameter int              ADDR_W    = 19,
   parameter logic [PIX_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [PIX_W-1:0]  din,
   input  logic              frame_done,
   input  logic              clear_start,
   input  logic              scan_start,
   input  logic              scan_ready,
   output logic              scan_valid,
   output logic [PIX_W-1:0]  scan_pixel,
   output logic [9:0]        scan_x,
   output logic [9:0]        scan_y,
   output logic              scan_last,
   output logic              scan_busy,
   output logic              clear_busy,
   output logic              swap_pend,
   output logic              front_sel,
   output logic [2:0]        err_flags
);
   localparam int NPIX = H_RES * V_RES;
   localparam int MEM_AW = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
   localparam logic [ADDR_W:0]   NPIX_EXT  = (ADDR_W + 1)'(NPIX);
   localparam logic [9:0]        LAST_X    = 10'(H_RES - 1);

   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
   typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_DRAIN} sc_state_t;

   clr_state_t        clr_state_reg;
   sc_state_t         sc_state_reg;
   logic [ADDR_W-1:0] clr_cnt_reg;
   logic              clear_busy_reg;
   logic [ADDR_W-1:0] rd_addr_reg;
   logic [9:0]        x_reg, y_reg;
   logic              p1_valid_reg, p1_last_reg;
   logic [9:0]        p1_x_reg, p1_y_reg;
   logic              scan_valid_reg, scan_last_reg, scan_busy_reg;
   logic [PIX_W-1:0]  scan_pixel_reg;
   logic [9:0]        scan_x_reg, scan_y_reg;
   logic              swap_pend_reg, front_sel_reg;
   logic [2:0]        err_reg;

   logic              addr_ok, swap_go, out_free, rd_issue;
   logic              wr_en;
   logic [MEM_AW-1:0] wr_idx, rd_idx;
   logic [PIX_W-1:0]  wr_data, rd_pix;

   assign addr_ok  = ({1'b0, addr} < NPIX_EXT);
   assign swap_go  = swap_pend_reg && !scan_busy_reg && !clear_busy_reg;
   assign out_free = !scan_valid_reg || scan_ready;
   // A read is only issued when its data is guaranteed a slot one cycle later.
   assign rd_issue = (sc_state_reg == SC_RUN) && (!p1_valid_reg || out_free) && !reset;
   assign rd_idx   = rd_addr_reg[MEM_AW-1:0];

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = addr[MEM_AW-1:0];
      wr_data = din;
      if (!reset) begin
         if (clear_busy_reg) begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_reg[MEM_AW-1:0];
            wr_data = CLEAR_VAL;
         end else if (wen && addr_ok) begin
            wr_en = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic [PIX_W-1:0] mem [0:NPIX-1];
         logic [PIX_W-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (wr_en && (front_sel_reg != 1'(gi)))
               mem[wr_idx] <= wr_data;
            if (rd_issue && (front_sel_reg == 1'(gi)))
               rd_q <= mem[rd_idx];
         end
      end
   endgenerate

   assign rd_pix = front_sel_reg ? g_bank[1].rd_q : g_bank[0].rd_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         clr_state_reg  <= CLR_IDLE;
         clear_busy_reg <= 1'b0;
         clr_cnt_reg    <= '0;
      end else begin
         case (clr_state_reg)
            CLR_IDLE: if (clear_start) begin
               clr_state_reg  <= CLR_RUN;
               clear_busy_reg <= 1'b1;
               clr_cnt_reg    <= '0;
            end
            CLR_RUN: begin
               if (clr_cnt_reg == LAST_ADDR) begin
                  clr_state_reg  <= CLR_IDLE;
                  clear_busy_reg <= 1'b0;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
               end
            end
            default: clr_state_reg <= CLR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sc_state_reg   <= SC_IDLE;
         scan_busy_reg  <= 1'b0;
         rd_addr_reg    <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         p1_valid_reg   <= 1'b0;
         p1_last_reg    <= 1'b0;
         p1_x_reg       <= '0;
         p1_y_reg       <= '0;
         scan_valid_reg <= 1'b0;
         scan_last_reg  <= 1'b0;
         scan_pixel_reg <= '0;
         scan_x_reg     <= '0;
         scan_y_reg     <= '0;
      end else begin
         case (sc_state_reg)
            SC_IDLE: if (scan_start) begin
               sc_state_reg  <= SC_RUN;
               scan_busy_reg <= 1'b1;
               rd_addr_reg   <= '0;
               x_reg         <= '0;
               y_reg         <= '0;
            end
            SC_RUN: if (rd_issue) begin
               if (rd_addr_reg == LAST_ADDR) begin
                  sc_state_reg <= SC_DRAIN;
               end else begin
                  rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
                  if (x_reg == LAST_X) begin
                     x_reg <= '0;
                     y_reg <= y_reg + 10'd1;
                  end else begin
                     x_reg <= x_reg + 10'd1;
                  end
               end
            end
            SC_DRAIN: if (scan_valid_reg && scan_ready && scan_last_reg) begin
               sc_state_reg  <= SC_IDLE;
               scan_busy_reg <= 1'b0;
            end
            default: sc_state_reg <= SC_IDLE;
         endcase

         // Stage 1 travels alongside the bank's registered read data.
         if (rd_issue) begin
            p1_valid_reg <= 1'b1;
            p1_x_reg     <= x_reg;
            p1_y_reg     <= y_reg;
            p1_last_reg  <= (rd_addr_reg == LAST_ADDR);
         end else if (out_free) begin
            p1_valid_reg <= 1'b0;
         end

         if (out_free) begin
            scan_valid_reg <= p1_valid_reg;
            if (p1_valid_reg) begin
               scan_pixel_reg <= rd_pix;
               scan_x_reg     <= p1_x_reg;
               scan_y_reg     <= p1_y_reg;
               scan_last_reg  <= p1_last_reg;
            end else begin
               scan_last_reg <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         swap_pend_reg <= 1'b0;
         front_sel_reg <= 1'b0;
         err_reg       <= '0;
      end else begin
         if (swap_go) begin
            front_sel_reg <= ~front_sel_reg;
            swap_pend_reg <= 1'b0;
         end else if (frame_done) begin
            swap_pend_reg <= 1'b1;
         end
         if (wen && !addr_ok)
            err_reg[0] <= 1'b1;
         if (wen && clear_busy_reg)
            err_reg[1] <= 1'b1;
         if (frame_done && swap_pend_reg)
            err_reg[2] <= 1'b1;
      end
   end

   assign scan_valid = scan_valid_reg;
   assign scan_pixel = scan_pixel_reg;
   assign scan_x     = scan_x_reg;
   assign scan_y     = scan_y_reg;
   assign scan_last  = scan_last_reg;
   assign scan_busy  = scan_busy_reg;
   assign clear_busy = clear_busy_reg;
   assign swap_pend  = swap_pend_reg;
   assign front_sel  = front_sel_reg;
   assign err_flags  = err_reg;
endmodule

// File: doc/fb_dual_bank.md
# fb_dual_bank

Parametrised, double-buffered framebuffer that sits between the `gpu` pixel-write port (`addr`/`wen`/`dout`) and any consumer that needs the finished image, such as a display scanner or a file dump.
- The GPU draws into the back bank; a row-major scan engine streams the front bank out over a valid/ready handshake.
- A frame-done pulse swaps the banks, deferred until both engines are idle.
- A clear engine fills the back bank with a constant before the next frame.

## Interface
Parameters:
- `H_RES`, 640, pixels per row
- `V_RES`, 480, rows per frame
- `PIX_W`, 6, pixel width (RRGGBB at default)
- `ADDR_W`, 19, address width; must satisfy `2**ADDR_W >= H_RES*V_RES`
- `CLEAR_VAL`, 0, pixel value written by the clear engine

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wen`  in  1  pixel write strobe from GPU
- `addr`  in  ADDR_W  pixel address, row-major (`y*H_RES + x`)
- `din`  in  PIX_W  pixel data
- `frame_done`  in  1  one-cycle pulse: back bank complete, request swap
- `clear_start`  in  1  start filling back bank with `CLEAR_VAL`
- `scan_start`  in  1  start streaming front bank
- `scan_ready`  in  1  consumer accepts `scan_pixel`
- `scan_valid`  out  1  `scan_pixel`/`scan_x`/`scan_y`/`scan_last` valid
- `scan_pixel`  out  PIX_W  front-bank pixel
- `scan_x`  out  10  column of `scan_pixel`
- `scan_y`  out  10  row of `scan_pixel`
- `scan_last`  out  1  high with pixel (`H_RES-1`, `V_RES-1`)
- `scan_busy`  out  1  scan engine active
- `clear_busy`  out  1  clear engine active
- `swap_pend`  out  1  swap requested, not yet performed
- `front_sel`  out  1  index of the front bank
- `err_flags`  out  3  sticky flags: [0] out-of-range write, [1] write dropped during clear, [2] `frame_done` while `swap_pend`

## Operation
- **Storage**
  - Two banks of `H_RES*V_RES` x `PIX_W`, each with one write port and one synchronous read port (1-cycle latency).
  - Back bank = `!front_sel`.
  - Contents are not reset.
- **Pixel writes**
  - With `wen` high and `addr < H_RES*V_RES`, `din` is written to the back bank at `addr`.
  - With `addr >= H_RES*V_RES`, no write occurs and `err_flags[0]` is set.
  - A write in any cycle with `clear_busy` high is dropped and `err_flags[1]` is set.
- **Clear engine** (states CLR_IDLE, CLR_RUN)
  - `clear_start` in CLR_IDLE moves the engine to CLR_RUN with the counter at 0.
  - CLR_RUN writes `CLEAR_VAL` at address = counter, one address per cycle.
  - After address `H_RES*V_RES-1` is written, the engine returns to CLR_IDLE.
  - `clear_start` while in CLR_RUN is ignored.
  - A `wen` in the same cycle as an accepted `clear_start` is performed; clear then overwrites that address.
- **Scan engine** (states SC_IDLE, SC_RUN, SC_DRAIN)
  - `scan_start` in SC_IDLE: x=y=0, move to SC_RUN.
  - SC_RUN issues front-bank reads in row-major order:
    - x increments; at x=`H_RES-1`, x wraps to 0 and y increments.
    - Reads stall whenever the output register is full and not being accepted, so no pixel is ever lost or duplicated.
  - After the read for the last pixel is issued, the engine moves to SC_DRAIN.
  - SC_DRAIN returns to SC_IDLE when the last pixel is accepted (`scan_valid && scan_ready && scan_last`).
  - `scan_start` while `scan_busy` is ignored.
  - `scan_x`/`scan_y` always match `scan_pixel`.
  - While `scan_valid && !scan_ready`, all scan outputs hold stable.
- **Swap**
  - `frame_done` sets `swap_pend`; if `swap_pend` is already set, `err_flags[2]` is set and only one swap occurs.
  - In any cycle with `swap_pend && !scan_busy && !clear_busy`, `front_sel` toggles and `swap_pend` clears on the next edge.
  - When `frame_done` arrives with both engines idle, the swap completes 2 edges after the pulse.
  - `scan_start` or `clear_start` in the same cycle that the swap executes is accepted and operates on the post-swap banks.
- **Arithmetic**
  - Counters are `ADDR_W` bits; `scan_x`/`scan_y` are 10 bits.
  - `H_RES`, `V_RES` <= 1024.

## Timing
- **Reset values:**
  - all-zero outputs: `scan_valid`, `scan_pixel`, `scan_x`, `scan_y`, `scan_last`, `scan_busy`, `clear_busy`, `swap_pend`, `front_sel`, `err_flags`
  - engine states: CLR_IDLE, SC_IDLE
- **Reset mid-operation:** both engines abort and all outputs return to reset values on the next edge; memory keeps its partial contents.
- **Busy signals:** `scan_busy` and `clear_busy` rise one cycle after an accepted start and stay high through the final transfer or write cycle.
- **Scan:**
  - First `scan_valid` = 2 cycles after the `scan_start` edge.
  - With `scan_ready` held high, one pixel per cycle and `H_RES*V_RES` consecutive valid cycles.
  - `scan_busy` falls the cycle after the last accept.
- **Clear:** occupies exactly `H_RES*V_RES` cycles of `clear_busy`.
- **Write visibility:** a written pixel is visible to a scan after the next swap.

## Test plan
Bench parameters: `H_RES`=8, `V_RES`=4, `PIX_W`=6.
- **Basic swap and scan:** write `pixel = addr[5:0]` to all 32 addresses, pulse `frame_done`, then `scan_start` with `scan_ready`=1.
  - `front_sel`=1; 32 consecutive valid beats with pixel 0..31 and x/y matching.
  - `scan_last` only on beat 31 (x=7, y=3).
- **Backpressure:** rerun the scan with `scan_ready` toggling pseudo-randomly.
  - Same 32-pixel sequence; outputs hold while stalled; no duplicates.
- **Clear during write:** `clear_start` in the same cycle as writes to addr 5, then `wen` at addr 9 mid-clear.
  - `clear_busy` high for 32 cycles; back bank all `CLEAR_VAL`; `err_flags[1]`=1.
- **Deferred swap:** `frame_done` while the scan is at beat 10.
  - `swap_pend`=1 and `front_sel` unchanged until the scan finishes; toggles the cycle after `scan_busy` falls.
- **Error flags:** write addr 40, then pulse `frame_done` twice while a clear is running.
  - `err_flags`=3'b101; no memory change; a single swap after the clear ends.
- **Reset mid-scan:** assert `reset` at beat 15.
  - Next cycle all outputs are 0; a new `scan_start` restarts at (0,0).
